// File: rtl/fp32_pkg.sv
// Shared FP32 constants, field layout and helpers for the matrix-multiply datapath.
package fp32_pkg;

    localparam int FP32_SIGN_W   = 1;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MAN_W    = 23;
    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_EXP_MAX  = 2 * FP32_EXP_BIAS + 1;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_PINF = 32'h7F800000;
    localparam logic [31:0] FP32_NINF = 32'hFF800000;

    typedef struct packed {
        logic [FP32_SIGN_W-1:0] sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_MAN_W-1:0]  man;
    } fp32_t;

    // Leading-zero count over the 27-bit GRS-extended mantissa.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_add_comb.sv
// Combinational FP32 adder: round-to-nearest-even, subnormals flushed to zero,
// canonical NaN, overflow to infinity with a flag.
module fp32_add_comb
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum,
    output logic        o_ovf
);

    fp32_t              w_a, w_b, w_big, w_sml;
    logic               w_aNan, w_bNan, w_aInf, w_bInf, w_aZero, w_bZero;
    logic               w_swap, w_effSub, w_roundUp;
    logic [7:0]         w_expDiff;
    logic [4:0]         w_shamt, w_lz;
    logic [26:0]        w_bigMan, w_smlMan, w_aligned, w_norm;
    logic [53:0]        w_shiftWide;
    logic [27:0]        w_rawSum;
    logic [24:0]        w_rounded;
    logic [22:0]        w_manFin;
    logic signed [9:0]  w_expPre, w_expFin;

    always_comb begin
        w_a      = i_a;
        w_b      = i_b;
        w_aNan   = (w_a.exp == 8'hFF) && (w_a.man != '0);
        w_bNan   = (w_b.exp == 8'hFF) && (w_b.man != '0);
        w_aInf   = (w_a.exp == 8'hFF) && (w_a.man == '0);
        w_bInf   = (w_b.exp == 8'hFF) && (w_b.man == '0);
        w_aZero  = (w_a.exp == 8'h00);
        w_bZero  = (w_b.exp == 8'h00);

        w_swap   = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
        w_big    = w_swap ? w_b : w_a;
        w_sml    = w_swap ? w_a : w_b;
        w_effSub = w_big.sign != w_sml.sign;

        // Alignment saturates at 27; everything shifted out collapses into sticky.
        w_expDiff   = w_big.exp - w_sml.exp;
        w_shamt     = (w_expDiff > 8'd27) ? 5'd27 : w_expDiff[4:0];
        w_bigMan    = {1'b1, w_big.man, 3'b000};
        w_smlMan    = {1'b1, w_sml.man, 3'b000};
        w_shiftWide = {w_smlMan, 27'd0} >> w_shamt;
        w_aligned   = w_shiftWide[53:27] | {26'd0, |w_shiftWide[26:0]};

        w_rawSum = w_effSub ? ({1'b0, w_bigMan} - {1'b0, w_aligned})
                            : ({1'b0, w_bigMan} + {1'b0, w_aligned});

        w_lz = 5'd0;
        if (!w_effSub && w_rawSum[27]) begin
            w_norm   = {w_rawSum[27:2], w_rawSum[1] | w_rawSum[0]};
            w_expPre = $signed({2'b00, w_big.exp}) + 10'sd1;
        end else begin
            w_lz     = lzc27(w_rawSum[26:0]);
            w_norm   = w_rawSum[26:0] << w_lz;
            w_expPre = $signed({2'b00, w_big.exp}) - $signed({5'd0, w_lz});
        end

        w_roundUp = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rounded = {1'b0, w_norm[26:3]} + {24'd0, w_roundUp};
        w_expFin  = w_expPre + (w_rounded[24] ? 10'sd1 : 10'sd0);
        w_manFin  = w_rounded[24] ? w_rounded[23:1] : w_rounded[22:0];

        o_ovf = 1'b0;
        if (w_aNan || w_bNan) begin
            o_sum = FP32_QNAN;
        end else if (w_aInf && w_bInf) begin
            o_sum = (w_a.sign != w_b.sign) ? FP32_QNAN : i_a;
        end else if (w_aInf) begin
            o_sum = i_a;
        end else if (w_bInf) begin
            o_sum = i_b;
        end else if (w_aZero && w_bZero) begin
            o_sum = {w_a.sign & w_b.sign, 31'd0};
        end else if (w_aZero) begin
            o_sum = i_b;
        end else if (w_bZero) begin
            o_sum = i_a;
        end else if (w_rawSum == '0) begin
            o_sum = 32'd0;
        end else if (w_expFin >= 10'sd255) begin
            o_sum = w_big.sign ? FP32_NINF : FP32_PINF;
            o_ovf = 1'b1;
        end else if (w_expFin <= 10'sd0) begin
            o_sum = 32'd0;
        end else begin
            o_sum = {w_big.sign, w_expFin[7:0], w_manFin};
        end
    end

endmodule

// File: rtl/fp32_dot_accumulator.sv
// Sums DOT_LEN consecutive FP32 products into one dot-product element and
// emits it with a one-cycle valid pulse; no backpressure.
module fp32_dot_accumulator
    import fp32_pkg::*;
#(
    parameter int DOT_LEN = 4,
    parameter int CNT_W   = $clog2(DOT_LEN) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_prod,
    input  logic        i_prod_vld,
    input  logic        i_ovf,
    output logic [31:0] o_res,
    output logic        o_res_vld,
    output logic        o_overflow,
    output logic        o_busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DOT_LEN - 1);

    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovfSticky;
    logic [31:0]      r_res;
    logic             r_resVld;
    logic             r_resOvf;
    logic [31:0]      w_sum;
    logic             w_addOvf;

    fp32_add_comb u_add (
        .i_a   (r_acc),
        .i_b   (i_prod),
        .o_sum (w_sum),
        .o_ovf (w_addOvf)
    );

    // The last element clears the running state on the same edge it emits,
    // so the next element can start a fresh sum without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= 32'd0;
            r_cnt       <= '0;
            r_ovfSticky <= 1'b0;
            r_res       <= 32'd0;
            r_resVld    <= 1'b0;
            r_resOvf    <= 1'b0;
        end else begin
            r_resVld <= 1'b0;
            if (i_prod_vld) begin
                if (r_cnt == LAST_IDX) begin
                    r_res       <= w_sum;
                    r_resOvf    <= r_ovfSticky | i_ovf | w_addOvf;
                    r_resVld    <= 1'b1;
                    r_acc       <= 32'd0;
                    r_cnt       <= '0;
                    r_ovfSticky <= 1'b0;
                end else begin
                    r_acc       <= w_sum;
                    r_cnt       <= r_cnt + CNT_W'(1);
                    r_ovfSticky <= r_ovfSticky | i_ovf | w_addOvf;
                end
            end
        end
    end

    assign o_res      = r_res;
    assign o_res_vld  = r_resVld;
    assign o_overflow = r_resOvf;
    assign o_busy     = (r_cnt != '0);

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Self-checking bench: directed and random product streams against a
// real-arithmetic reference model of the dot-product accumulator.
module tb_fp32_dot_accumulator;

    localparam int DOT_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_prod = 32'd0;
    logic        i_prod_vld = 1'b0;
    logic        i_ovf = 1'b0;
    logic [31:0] o_res;
    logic        o_res_vld;
    logic        o_overflow;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mAcc = 32'd0;
    int          mCnt = 0;
    logic        mOvf = 1'b0;
    logic [31:0] mRes = 32'd0;
    logic        mResOvf = 1'b0;
    logic        mVld = 1'b0;

    fp32_dot_accumulator #(.DOT_LEN(DOT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_prod     (i_prod),
        .i_prod_vld (i_prod_vld),
        .i_ovf      (i_ovf),
        .o_res      (o_res),
        .o_res_vld  (o_res_vld),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Exact widening of a normal FP32 value to a real.
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] b;
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        b = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    // Round a nonzero real to FP32 (nearest-even); {overflow, value}.
    function automatic logic [32:0] r2f(input real d);
        logic [63:0] bits;
        logic [24:0] m;
        logic [28:0] rem;
        logic [7:0]  e8;
        int          e;
        bits = $realtobits(d);
        e    = int'(bits[62:52]) - 1023 + 127;
        m    = {2'b01, bits[51:29]};
        rem  = bits[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {1'b1, bits[63], 8'hFF, 23'd0};
        if (e <= 0) return 33'd0;
        e8 = 8'(e);
        return {1'b0, bits[63], e8, m[22:0]};
    endfunction

    function automatic logic [32:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        logic aNan, bNan, aInf, bInf;
        real  s;
        aNan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bNan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        aInf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bInf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (aNan || bNan) return {1'b0, 32'h7FC00000};
        if (aInf && bInf) return (a[31] != b[31]) ? {1'b0, 32'h7FC00000} : {1'b0, a};
        if (aInf) return {1'b0, a};
        if (bInf) return {1'b0, b};
        if (a[30:23] == 0 && b[30:23] == 0) return {1'b0, a[31] & b[31], 31'd0};
        s = f2r(a) + f2r(b);
        if (s == 0.0) return 33'd0;
        return r2f(s);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%08h expected=%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("res_vld",  {31'd0, o_res_vld},  {31'd0, mVld});
        checkOutput("res",      o_res,               mRes);
        checkOutput("overflow", {31'd0, o_overflow}, {31'd0, mResOvf});
        checkOutput("busy",     {31'd0, o_busy},     {31'd0, (mCnt != 0)});
    endtask

    task automatic applyStimulus(input logic vld, input logic [31:0] prod, input logic ovf);
        logic [32:0] r;
        @(negedge clk);
        checkCycle();
        mVld       = 1'b0;
        i_prod_vld = vld;
        i_prod     = prod;
        i_ovf      = ovf;
        if (vld) begin
            r    = refAdd(mAcc, prod);
            mOvf = mOvf | ovf | r[32];
            if (mCnt == DOT_LEN - 1) begin
                mRes    = r[31:0];
                mResOvf = mOvf;
                mVld    = 1'b1;
                mAcc    = 32'd0;
                mCnt    = 0;
                mOvf    = 1'b0;
            end else begin
                mAcc = r[31:0];
                mCnt = mCnt + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom, 1'($urandom));
    endtask

    task automatic feed4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        applyStimulus(1'b1, a, 1'b0);
        applyStimulus(1'b1, b, 1'b0);
        applyStimulus(1'b1, c, 1'b0);
        applyStimulus(1'b1, d, 1'b0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        i_prod_vld = 1'b0;
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_res",      o_res,               32'd0);
        checkOutput("rst_res_vld",  {31'd0, o_res_vld},  32'd0);
        checkOutput("rst_overflow", {31'd0, o_overflow}, 32'd0);
        checkOutput("rst_busy",     {31'd0, o_busy},     32'd0);
        mAcc = 32'd0; mCnt = 0; mOvf = 1'b0;
        mRes = 32'd0; mResOvf = 1'b0; mVld = 1'b0;
        #1 rst = 1'b1;
    endtask

    function automatic logic [31:0] randFloat();
        logic [7:0] e;
        e = 8'($urandom_range(140, 110));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        applyReset();

        feed4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        idle(1);
        checkOutput("sum_10", o_res, 32'h41200000);
        idle(2);

        feed4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        feed4(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
        idle(1);
        checkOutput("sum_2", o_res, 32'h40000000);
        idle(1);

        applyStimulus(1'b1, 32'h40C00000, 1'b0); idle(2);
        applyStimulus(1'b1, 32'hC0C00000, 1'b0); idle(2);
        applyStimulus(1'b1, 32'h00000000, 1'b0); idle(2);
        applyStimulus(1'b1, 32'h80000000, 1'b0); idle(2);
        checkOutput("sum_zero", o_res, 32'h00000000);

        feed4(32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000);
        idle(1);
        checkOutput("inf_minus_inf", o_res, 32'h7FC00000);
        feed4(32'h3F800000, 32'h7FC00000, 32'h40000000, 32'h40400000);
        idle(1);
        checkOutput("nan_in", o_res, 32'h7FC00000);

        feed4(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000);
        idle(1);
        checkOutput("ovf_res", o_res, 32'h7F800000);
        checkOutput("ovf_flag", {31'd0, o_overflow}, 32'd1);
        feed4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        idle(1);
        checkOutput("after_ovf", o_res, 32'h40800000);
        checkOutput("after_ovf_flag", {31'd0, o_overflow}, 32'd0);

        applyStimulus(1'b1, 32'h3F800000, 1'b0);
        applyStimulus(1'b1, 32'h3F800000, 1'b1);
        applyStimulus(1'b1, 32'h3F800000, 1'b0);
        applyStimulus(1'b1, 32'h3F800000, 1'b0);
        feed4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        idle(1);

        applyStimulus(1'b1, 32'h42C80000, 1'b0);
        applyStimulus(1'b1, 32'h42C80000, 1'b0);
        applyReset();
        feed4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        idle(1);
        checkOutput("post_reset", o_res, 32'h41200000);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9, 0) < 7)
                applyStimulus(1'b1, randFloat(), ($urandom_range(15, 0) == 0));
            else
                applyStimulus(1'b0, $urandom, 1'($urandom));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
